// File: rtl/rps_match_controller.sv
// Best-of-N rock-paper-scissors match sequencer: collects one move per player
// per round over valid/ready, judges the round, keeps scores and picks the winner.
module rps_match_controller #(
  parameter int unsigned WINS_NEEDED = 2,
  parameter int unsigned MAX_ROUNDS  = 9,
  parameter int unsigned SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               a_valid,
  input  logic [1:0]         a_move,
  output logic               a_ready,
  input  logic               b_valid,
  input  logic [1:0]         b_move,
  output logic               b_ready,
  output logic               round_valid,
  output logic [1:0]         round_result,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic [SCORE_W-1:0] round_cnt,
  output logic               err_invalid,
  output logic               match_done,
  output logic [1:0]         match_winner
);

  typedef enum logic [1:0] {IDLE, COLLECT, RESULT, DONE} state_t;

  localparam logic [SCORE_W-1:0] WINS  = SCORE_W'(WINS_NEEDED);
  localparam logic [SCORE_W-1:0] LIMIT = SCORE_W'(MAX_ROUNDS);

  state_t             state, state_n;
  logic               held_a, held_b, held_a_n, held_b_n;
  logic [1:0]         mv_a, mv_b, mv_a_n, mv_b_n;
  logic               a_ready_n, b_ready_n, round_valid_n, err_invalid_n, match_done_n;
  logic [1:0]         round_result_n, match_winner_n, verdict;
  logic [SCORE_W-1:0] score_a_n, score_b_n, round_cnt_n;

  // 00 tesoura, 01 pedra, 10 papel: each move beats the one encoded just below it (mod 3)
  function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] r;
    r = 2'b00;
    if (a != b) begin
      case ({a, b})
        4'b01_00, 4'b00_10, 4'b10_01: r = 2'b01;
        default:                      r = 2'b10;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    state_n        = state;
    held_a_n       = held_a;
    held_b_n       = held_b;
    mv_a_n         = mv_a;
    mv_b_n         = mv_b;
    a_ready_n      = a_ready;
    b_ready_n      = b_ready;
    round_valid_n  = 1'b0;
    err_invalid_n  = 1'b0;
    round_result_n = round_result;
    score_a_n      = score_a;
    score_b_n      = score_b;
    round_cnt_n    = round_cnt;
    match_done_n   = match_done;
    match_winner_n = match_winner;
    verdict        = 2'b00;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n        = COLLECT;
          score_a_n      = '0;
          score_b_n      = '0;
          round_cnt_n    = '0;
          match_winner_n = '0;
          match_done_n   = 1'b0;
          held_a_n       = 1'b0;
          held_b_n       = 1'b0;
          a_ready_n      = 1'b1;
          b_ready_n      = 1'b1;
        end
      end
      COLLECT: begin
        if (a_valid && a_ready) begin
          if (a_move == 2'b11) begin
            err_invalid_n = 1'b1;
          end else begin
            mv_a_n    = a_move;
            held_a_n  = 1'b1;
            a_ready_n = 1'b0;
          end
        end
        if (b_valid && b_ready) begin
          if (b_move == 2'b11) begin
            err_invalid_n = 1'b1;
          end else begin
            mv_b_n    = b_move;
            held_b_n  = 1'b1;
            b_ready_n = 1'b0;
          end
        end
        // Judge on the same edge the second move lands, using the freshly latched values
        if (held_a_n && held_b_n) begin
          verdict        = judge(mv_a_n, mv_b_n);
          state_n        = RESULT;
          a_ready_n      = 1'b0;
          b_ready_n      = 1'b0;
          round_result_n = verdict;
          round_valid_n  = 1'b1;
          round_cnt_n    = round_cnt + 1'b1;
          if (verdict == 2'b01) score_a_n = score_a + 1'b1;
          if (verdict == 2'b10) score_b_n = score_b + 1'b1;
        end
      end
      RESULT: begin
        if (score_a == WINS || score_b == WINS || round_cnt == LIMIT) begin
          state_n      = DONE;
          match_done_n = 1'b1;
          if (score_a > score_b)      match_winner_n = 2'b01;
          else if (score_b > score_a) match_winner_n = 2'b10;
          else                        match_winner_n = 2'b00;
        end else begin
          state_n   = COLLECT;
          held_a_n  = 1'b0;
          held_b_n  = 1'b0;
          a_ready_n = 1'b1;
          b_ready_n = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      held_a       <= 1'b0;
      held_b       <= 1'b0;
      mv_a         <= '0;
      mv_b         <= '0;
      a_ready      <= 1'b0;
      b_ready      <= 1'b0;
      round_valid  <= 1'b0;
      err_invalid  <= 1'b0;
      round_result <= '0;
      score_a      <= '0;
      score_b      <= '0;
      round_cnt    <= '0;
      match_done   <= 1'b0;
      match_winner <= '0;
    end else begin
      state        <= state_n;
      held_a       <= held_a_n;
      held_b       <= held_b_n;
      mv_a         <= mv_a_n;
      mv_b         <= mv_b_n;
      a_ready      <= a_ready_n;
      b_ready      <= b_ready_n;
      round_valid  <= round_valid_n;
      err_invalid  <= err_invalid_n;
      round_result <= round_result_n;
      score_a      <= score_a_n;
      score_b      <= score_b_n;
      round_cnt    <= round_cnt_n;
      match_done   <= match_done_n;
      match_winner <= match_winner_n;
    end
  end

endmodule

// File: tb/tb_rps_match_controller.sv
// Bench for rps_match_controller: directed match scenarios plus random play,
// every cycle checked against a match-level model of the rules.
module tb_rps_match_controller;

  localparam int WINS = 2;
  localparam int MAXR = 9;
  localparam int SW   = 4;

  localparam int PH_IDLE   = 0;
  localparam int PH_PLAY   = 1;
  localparam int PH_JUDGED = 2;
  localparam int PH_OVER   = 3;

  logic          clk = 1'b0;
  logic          rst, start, a_valid, b_valid;
  logic [1:0]    a_move, b_move;
  logic          a_ready, b_ready, round_valid, err_invalid, match_done;
  logic [1:0]    round_result, match_winner;
  logic [SW-1:0] score_a, score_b, round_cnt;

  rps_match_controller #(
    .WINS_NEEDED(WINS),
    .MAX_ROUNDS (MAXR),
    .SCORE_W    (SW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a_valid     (a_valid),
    .a_move      (a_move),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_move      (b_move),
    .b_ready     (b_ready),
    .round_valid (round_valid),
    .round_result(round_result),
    .score_a     (score_a),
    .score_b     (score_b),
    .round_cnt   (round_cnt),
    .err_invalid (err_invalid),
    .match_done  (match_done),
    .match_winner(match_winner)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Match-level model
  int m_phase, m_ma, m_mb, m_res, m_sa, m_sb, m_cnt, m_win;
  bit m_ha, m_hb, m_ra, m_rb, m_rv, m_err, m_done;
  bit acc_a, acc_b;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    int d;
    if (rst) begin
      m_phase = PH_IDLE; m_ha = 0; m_hb = 0; m_ra = 0; m_rb = 0; m_ma = 0; m_mb = 0;
      m_rv = 0; m_err = 0; m_res = 0; m_sa = 0; m_sb = 0; m_cnt = 0; m_done = 0; m_win = 0;
      return;
    end
    m_rv = 0;
    m_err = 0;
    case (m_phase)
      PH_IDLE, PH_OVER: begin
        if (start) begin
          m_sa = 0; m_sb = 0; m_cnt = 0; m_win = 0; m_done = 0;
          m_ha = 0; m_hb = 0; m_ra = 1; m_rb = 1; m_phase = PH_PLAY;
        end
      end
      PH_PLAY: begin
        if (a_valid && m_ra) begin
          if (a_move == 2'd3) m_err = 1;
          else begin m_ma = int'(a_move); m_ha = 1; m_ra = 0; end
        end
        if (b_valid && m_rb) begin
          if (b_move == 2'd3) m_err = 1;
          else begin m_mb = int'(b_move); m_hb = 1; m_rb = 0; end
        end
        if (m_ha && m_hb) begin
          // move k beats move k-1 (mod 3); result code equals the winner's index
          d = (m_ma - m_mb + 3) % 3;
          m_res = d;
          if (d == 1) m_sa++;
          if (d == 2) m_sb++;
          m_cnt++;
          m_rv = 1;
          m_phase = PH_JUDGED;
        end
      end
      default: begin
        if (m_sa == WINS || m_sb == WINS || m_cnt == MAXR) begin
          m_win = (m_sa > m_sb) ? 1 : (m_sb > m_sa) ? 2 : 0;
          m_done = 1;
          m_phase = PH_OVER;
        end else begin
          m_ha = 0; m_hb = 0; m_ra = 1; m_rb = 1; m_phase = PH_PLAY;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("a_ready",      int'(a_ready),      int'(m_ra));
    check("b_ready",      int'(b_ready),      int'(m_rb));
    check("round_valid",  int'(round_valid),  int'(m_rv));
    check("round_result", int'(round_result), m_res);
    check("score_a",      int'(score_a),      m_sa);
    check("score_b",      int'(score_b),      m_sb);
    check("round_cnt",    int'(round_cnt),    m_cnt);
    check("err_invalid",  int'(err_invalid),  int'(m_err));
    check("match_done",   int'(match_done),   int'(m_done));
    check("match_winner", int'(match_winner), m_win);
  endtask

  task automatic tick();
    @(posedge clk);
    acc_a = a_valid && m_ra;
    acc_b = b_valid && m_rb;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  // Both players offer in the same cycle, then release; leaves the bench one cycle past RESULT
  task automatic play_round(input logic [1:0] a, input logic [1:0] b, input int exp_res);
    a_valid = 1; a_move = a; b_valid = 1; b_move = b;
    tick();
    check("lit_round_valid", int'(round_valid), 1);
    check("lit_round_result", int'(round_result), exp_res);
    a_valid = 0; b_valid = 0;
    tick();
  endtask

  initial begin
    rst = 1; start = 0; a_valid = 0; b_valid = 0; a_move = 0; b_move = 0;
    tick();
    tick();
    check("lit_reset_ready", int'(a_ready) + int'(b_ready), 0);
    check("lit_reset_done", int'(match_done), 0);
    rst = 0;

    // Reset in the middle of a round with A's move already held
    start = 1; tick(); start = 0;
    a_valid = 1; a_move = 2'b01; tick(); a_valid = 0;
    check("lit_a_held_ready", int'(a_ready), 0);
    rst = 1; tick(); rst = 0;
    check("lit_rst_mid_outputs",
          int'(a_ready) + int'(b_ready) + int'(round_valid) + int'(round_result)
          + int'(score_a) + int'(score_b) + int'(round_cnt) + int'(err_invalid)
          + int'(match_done) + int'(match_winner), 0);
    start = 1; tick(); start = 0;
    check("lit_restart_a_ready", int'(a_ready), 1);
    check("lit_restart_b_ready", int'(b_ready), 1);

    // A wins two straight rounds
    play_round(2'b01, 2'b00, 1);
    check("lit_score_a_r1", int'(score_a), 1);
    play_round(2'b10, 2'b01, 1);
    check("lit_match_done", int'(match_done), 1);
    check("lit_match_winner_a", int'(match_winner), 1);
    check("lit_round_cnt_2", int'(round_cnt), 2);
    check("lit_score_a_2", int'(score_a), 2);

    // Rematch, and a start pulse in the middle of collection is ignored
    start = 1; tick(); start = 0;
    check("lit_rematch_clear", int'(score_a) + int'(score_b) + int'(round_cnt) + int'(match_winner), 0);
    check("lit_rematch_done", int'(match_done), 0);
    check("lit_rematch_ready", int'(a_ready) + int'(b_ready), 2);
    start = 1; tick(); start = 0;
    check("lit_start_ignored", int'(a_ready) + int'(b_ready), 2);

    // Staggered handshake: A at t, B at t+3
    a_valid = 1; a_move = 2'b00; tick(); a_valid = 0;
    check("lit_stag_a_ready", int'(a_ready), 0);
    check("lit_stag_b_ready", int'(b_ready), 1);
    tick(); tick();
    check("lit_stag_b_still", int'(b_ready), 1);
    check("lit_stag_no_result", int'(round_valid), 0);
    b_valid = 1; b_move = 2'b10; tick(); b_valid = 0;
    check("lit_stag_valid", int'(round_valid), 1);
    check("lit_stag_result", int'(round_result), 1);
    tick();

    // Invalid move is discarded
    a_valid = 1; a_move = 2'b11; tick(); a_valid = 0;
    check("lit_err_pulse", int'(err_invalid), 1);
    check("lit_err_a_ready", int'(a_ready), 1);
    check("lit_err_no_round", int'(round_valid), 0);
    tick();
    check("lit_err_cleared", int'(err_invalid), 0);
    play_round(2'b01, 2'b10, 2);
    check("lit_err_score_b", int'(score_b), 1);

    // Nine draws hit the round limit
    rst = 1; tick(); rst = 0;
    start = 1; tick(); start = 0;
    for (int r = 0; r < MAXR; r++) play_round(2'b01, 2'b01, 0);
    check("lit_draw_done", int'(match_done), 1);
    check("lit_draw_winner", int'(match_winner), 0);
    check("lit_draw_cnt", int'(round_cnt), 9);
    check("lit_draw_scores", int'(score_a) + int'(score_b), 0);

    // Random play; players hold an offer until it is taken
    acc_a = 1; acc_b = 1;
    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 7) == 0);
      if (!a_valid || acc_a) begin
        a_valid = 1'($urandom_range(0, 1));
        a_move  = 2'($urandom_range(0, 3));
      end
      if (!b_valid || acc_b) begin
        b_valid = 1'($urandom_range(0, 1));
        b_move  = 2'($urandom_range(0, 3));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
